// File: rtl/sfx_pkg.sv
// sfx_pkg: effect kinds, note frequencies and per-kind note tables
// shared by the tone sequencer and its square-wave generator.
package sfx_pkg;

   typedef enum logic [1:0] {SFX_JUMP, SFX_WIN, SFX_LOSE} sfx_e;
   typedef enum logic [1:0] {IDLE, PLAY, GAP} seqState_e;

   localparam int F_C4 = 262;
   localparam int F_E4 = 330;
   localparam int F_G4 = 392;
   localparam int F_C5 = 523;
   localparam int F_E5 = 659;
   localparam int F_G5 = 784;
   localparam int F_C6 = 1047;
   localparam int REST = 0;

   localparam int MAX_NOTES = 4;
   localparam int SEQ_LEN [3] = '{2, 4, 4};
   localparam int SEQ_NOTES [3][MAX_NOTES] = '{
      '{F_C5, F_G5, REST, REST},
      '{F_C5, F_E5, F_G5, F_C6},
      '{F_G4, F_E4, F_C4, REST}
   };

   // REST maps to a zero half-period, which the generator treats as silence
   function automatic int halfPeriod(input int clkHz, input int freq);
      return (freq == REST) ? 0 : clkHz / (2 * freq);
   endfunction

endpackage

// File: rtl/square_wave_gen.sv
// square_wave_gen: toggles its output every `half` enabled cycles.
// Held low while disabled, cleared, or given a zero half-period.
module square_wave_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] half,
   output logic         tone
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (clr || !en || half == '0) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (cnt == half - W'(1)) begin
         cnt  <= '0;
         tone <= ~tone;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// sfx_tone_sequencer: plays a fixed note sequence as a square wave on trigger.
// Optional SFX_MUTE_EN adds a mute input gating sound_out after the toggle.
module sfx_tone_sequencer
   import sfx_pkg::*;
#(
   parameter int   CLK_HZ   = 12_000_000,
   parameter int   NOTE_MS  = 60,
   parameter int   GAP_MS   = 10,
   parameter sfx_e SFX_KIND = SFX_JUMP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
`ifdef SFX_MUTE_EN
   input  logic mute,
`endif
   output logic sound_out,
   output logic busy,
   output logic done
);

   localparam int NOTE_CYC = int'((longint'(CLK_HZ) * NOTE_MS) / 1000);
   localparam int GAP_CYC  = int'((longint'(CLK_HZ) * GAP_MS) / 1000);
   localparam int NOTE_W   = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
   localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int HALF_MAX = halfPeriod(CLK_HZ, F_C4);
   localparam int HALF_W   = (HALF_MAX > 0) ? $clog2(HALF_MAX + 1) : 1;
   localparam int IDX_W    = $clog2(MAX_NOTES);
   localparam int KIND     = int'(SFX_KIND);
   localparam int LAST     = SEQ_LEN[KIND] - 1;
   localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   seqState_e         state;
   logic [IDX_W-1:0]  noteIdx;
   logic [NOTE_W-1:0] noteCnt;
   logic [GAP_W-1:0]  gapCnt;
   logic [HALF_W-1:0] halfTab [MAX_NOTES];
   logic              noteEnd;
   logic              gapEnd;
   logic              lastNote;
   logic              playing;
   logic              tone;

   for (genvar g = 0; g < MAX_NOTES; g++) begin : gHalf
      assign halfTab[g] =
         HALF_W'(halfPeriod(CLK_HZ, SEQ_NOTES[KIND][g]));
   end

   assign playing  = (state == PLAY);
   assign noteEnd  = (noteCnt == NOTE_W'(NOTE_CYC - 1));
   assign gapEnd   = (gapCnt == GAP_W'(GAP_LAST));
   assign lastNote = (noteIdx == IDX_W'(LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         noteIdx <= '0;
         noteCnt <= '0;
         gapCnt  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (trigger) begin
            state   <= PLAY;
            noteIdx <= '0;
            noteCnt <= '0;
            gapCnt  <= '0;
            busy    <= 1'b1;
         end else begin
            unique case (state)
               IDLE: ;
               PLAY: begin
                  if (!noteEnd) begin
                     noteCnt <= noteCnt + NOTE_W'(1);
                  end else begin
                     noteCnt <= '0;
                     if (GAP_CYC > 0) begin
                        state <= GAP;
                     end else if (lastNote) begin
                        state   <= IDLE;
                        noteIdx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        noteIdx <= noteIdx + IDX_W'(1);
                     end
                  end
               end
               GAP: begin
                  if (!gapEnd) begin
                     gapCnt <= gapCnt + GAP_W'(1);
                  end else begin
                     gapCnt <= '0;
                     if (lastNote) begin
                        state   <= IDLE;
                        noteIdx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        state   <= PLAY;
                        noteIdx <= noteIdx + IDX_W'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Clear on the edge that ends a note or restarts, so each note starts low
   square_wave_gen #(
      .W(HALF_W)
   ) uWave (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (playing),
      .clr  (playing && (noteEnd || trigger)),
      .half (halfTab[noteIdx]),
      .tone (tone)
   );

`ifdef SFX_MUTE_EN
   assign sound_out = tone & ~mute;
`else
   assign sound_out = tone;
`endif

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// tb_sfx_tone_sequencer: three sequencer instances checked cycle by cycle
// against a timeline model built from note lengths and frequencies.
module tb_sfx_tone_sequencer;

   localparam int CLK_HZ = 100_000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] trig = '0;
   logic [2:0] snd;
   logic [2:0] bsy;
   logic [2:0] dn;
   logic       muteOn = 1'b0;
`ifdef SFX_MUTE_EN
   logic       mute = 1'b0;
`endif

   int seqLen [3] = '{2, 4, 4};
   int freqs [3][4] = '{
      '{523, 784, 0, 0},
      '{523, 659, 784, 1047},
      '{392, 330, 262, 0}
   };
   int noteCyc [3] = '{100, 100, 300};
   int gapCyc [3] = '{0, 100, 0};

   bit         active [3];
   longint     startC [3];
   longint     cyc = 0;
   logic [2:0] obsV [3];
   logic [2:0] expV [3];
   logic       prevSnd [3];
   bit         edgeV [3];
   int         nCmp = 0;
   int         nBad = 0;

   always #5 clk = ~clk;

   sfx_tone_sequencer #(
      .CLK_HZ(CLK_HZ), .NOTE_MS(1), .GAP_MS(0),
      .SFX_KIND(sfx_pkg::SFX_JUMP)
   ) uJump (
      .clk(clk), .rst_n(rst_n), .trigger(trig[0]),
`ifdef SFX_MUTE_EN
      .mute(mute),
`endif
      .sound_out(snd[0]), .busy(bsy[0]), .done(dn[0])
   );

   sfx_tone_sequencer #(
      .CLK_HZ(CLK_HZ), .NOTE_MS(1), .GAP_MS(1),
      .SFX_KIND(sfx_pkg::SFX_WIN)
   ) uWin (
      .clk(clk), .rst_n(rst_n), .trigger(trig[1]),
`ifdef SFX_MUTE_EN
      .mute(mute),
`endif
      .sound_out(snd[1]), .busy(bsy[1]), .done(dn[1])
   );

   sfx_tone_sequencer #(
      .CLK_HZ(CLK_HZ), .NOTE_MS(3), .GAP_MS(0),
      .SFX_KIND(sfx_pkg::SFX_LOSE)
   ) uLose (
      .clk(clk), .rst_n(rst_n), .trigger(trig[2]),
`ifdef SFX_MUTE_EN
      .mute(mute),
`endif
      .sound_out(snd[2]), .busy(bsy[2]), .done(dn[2])
   );

   // {sound, busy, done} expected in the current cycle
   function automatic logic [2:0] modelOut(input int i);
      longint e, len, tot, k;
      int     idx, h;
      logic   s;
      if (!active[i]) return 3'b000;
      len = noteCyc[i] + gapCyc[i];
      tot = seqLen[i] * len;
      e   = cyc - startC[i];
      if (e == tot) return 3'b001;
      if (e > tot) return 3'b000;
      idx = int'(e / len);
      k   = e % len;
      h   = (freqs[i][idx] == 0) ? 0 : CLK_HZ / (2 * freqs[i][idx]);
      s   = (k < noteCyc[i] && h != 0) ? (((k / h) % 2) == 1) : 1'b0;
      return {s & ~muteOn, 1'b1, 1'b0};
   endfunction

   task automatic step(input logic [2:0] tv, input logic m);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         obsV[i]    = {snd[i], bsy[i], dn[i]};
         expV[i]    = modelOut(i);
         edgeV[i]   = (snd[i] !== prevSnd[i]);
         prevSnd[i] = snd[i];
      end
      trig   = tv;
      muteOn = m;
`ifdef SFX_MUTE_EN
      mute = m;
`endif
      for (int i = 0; i < 3; i++) begin
         if (tv[i]) begin
            active[i] = 1'b1;
            startC[i] = cyc + 1;
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         active[i]  = 1'b0;
         prevSnd[i] = 1'b0;
      end
      for (int n = 0; n < 5; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== 3'b000) begin
               nBad++;
               $display("FAIL reset dut%0d got %b want 000", i, obsV[i]);
            end
         end
      end
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL idle dut%0d got %b want %b", i, obsV[i], expV[i]);
            end
         end
      end
   endtask

   task automatic test_jump();
      longint tr, rise, doneAt, fall;
      int     e1, e2;
      rise = -1; doneAt = -1; fall = -1; e1 = 0; e2 = 0;
      step(3'b001, 1'b0);
      tr = cyc;
      for (int n = 1; n <= 250; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL jump_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (edgeV[0] && snd[0] && rise < 0) rise = cyc - tr;
         if (dn[0] && doneAt < 0) doneAt = cyc - tr;
         if (!bsy[0] && n > 1 && fall < 0) fall = cyc - tr;
         if (edgeV[0] && n <= 100) e1++;
         if (edgeV[0] && n > 100 && n <= 201) e2++;
      end
      nCmp++;
      if (rise !== 96) begin
         nBad++;
         $display("FAIL jump_first_toggle got %0d want 96", rise);
      end
      nCmp++;
      if (doneAt !== 201 || fall !== 201) begin
         nBad++;
         $display("FAIL jump_done got done=%0d fall=%0d want 201", doneAt, fall);
      end
      nCmp++;
      if (e1 !== 1 || e2 !== 3) begin
         nBad++;
         $display("FAIL jump_toggles got %0d/%0d want 1/3", e1, e2);
      end
   endtask

   task automatic test_win();
      int busyCnt, doneCnt;
      busyCnt = 0; doneCnt = 0;
      step(3'b010, 1'b0);
      for (int n = 1; n <= 820; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL win_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (bsy[1]) busyCnt++;
         if (dn[1]) doneCnt++;
      end
      nCmp++;
      if (busyCnt !== 800 || doneCnt !== 1) begin
         nBad++;
         $display("FAIL win_busy got busy=%0d done=%0d want 800/1",
                  busyCnt, doneCnt);
      end
   endtask

   task automatic test_retrigger();
      longint tr, doneAt;
      int     doneCnt;
      doneAt = -1; doneCnt = 0;
      step(3'b001, 1'b0);
      tr = cyc;
      for (int n = 1; n <= 320; n++) begin
         step((n == 98) ? 3'b001 : 3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL retrig_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (n == 98) begin
            nCmp++;
            if (snd[0] !== 1'b1) begin
               nBad++;
               $display("FAIL retrig_pre got %b want 1", snd[0]);
            end
         end
         if (n == 99) begin
            nCmp++;
            if (snd[0] !== 1'b0 || bsy[0] !== 1'b1) begin
               nBad++;
               $display("FAIL retrig_restart got snd=%b busy=%b want 0/1",
                        snd[0], bsy[0]);
            end
         end
         if (dn[0]) begin
            doneCnt++;
            doneAt = cyc - tr;
         end
      end
      nCmp++;
      if (doneCnt !== 1 || doneAt !== 299) begin
         nBad++;
         $display("FAIL retrig_done got cnt=%0d at=%0d want 1 at 299",
                  doneCnt, doneAt);
      end
   endtask

   task automatic test_back_to_back();
      longint tr, doneAt;
      int     doneCnt;
      doneAt = -1; doneCnt = 0;
      step(3'b001, 1'b0);
      tr = cyc;
      for (int n = 1; n <= 420; n++) begin
         step((n == 200) ? 3'b001 : 3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL b2b_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (n == 201) begin
            nCmp++;
            if (bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin
               nBad++;
               $display("FAIL b2b_suppress got busy=%b done=%b want 1/0",
                        bsy[0], dn[0]);
            end
         end
         if (dn[0]) begin
            doneCnt++;
            doneAt = cyc - tr;
         end
      end
      nCmp++;
      if (doneCnt !== 1 || doneAt !== 401) begin
         nBad++;
         $display("FAIL b2b_done got cnt=%0d at=%0d want 1 at 401",
                  doneCnt, doneAt);
      end
   endtask

   task automatic test_lose_rest();
      int hi1, hi4;
      hi1 = 0; hi4 = 0;
      step(3'b100, 1'b0);
      for (int n = 1; n <= 1220; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL lose_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (snd[2] && n <= 300) hi1++;
         if (snd[2] && n > 900 && n <= 1200) hi4++;
      end
      nCmp++;
      if (hi4 !== 0 || hi1 == 0) begin
         nBad++;
         $display("FAIL lose_rest got note1_hi=%0d note4_hi=%0d want >0/0",
                  hi1, hi4);
      end
   endtask

   task automatic test_reset_abort();
      int doneCnt;
      doneCnt = 0;
      step(3'b100, 1'b0);
      for (int n = 1; n <= 450; n++) step(3'b000, 1'b0);
      nCmp++;
      if (bsy[2] !== 1'b1) begin
         nBad++;
         $display("FAIL abort_pre busy got %b want 1", bsy[2]);
      end
      #2 rst_n = 1'b0;
      #1;
      nCmp++;
      if ({snd, bsy, dn} !== 9'b0) begin
         nBad++;
         $display("FAIL abort_async got %b want 0", {snd, bsy, dn});
      end
      for (int i = 0; i < 3; i++) active[i] = 1'b0;
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      rst_n = 1'b1;
      for (int n = 0; n < 300; n++) begin
         step(3'b000, 1'b0);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL abort_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (dn[2]) doneCnt++;
      end
      nCmp++;
      if (doneCnt !== 0) begin
         nBad++;
         $display("FAIL abort_done got %0d pulses want 0", doneCnt);
      end
   endtask

`ifdef SFX_MUTE_EN
   task automatic test_mute();
      longint tr, doneAt;
      int     hiMuted, edgesAfter;
      doneAt = -1; hiMuted = 0; edgesAfter = 0;
      step(3'b001, 1'b0);
      tr = cyc;
      for (int n = 1; n <= 250; n++) begin
         step(3'b000, (n >= 40 && n < 140));
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL mute_model n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
         if (snd[0] && n > 40 && n <= 140) hiMuted++;
         if (edgeV[0] && n > 141) edgesAfter++;
         if (dn[0] && doneAt < 0) doneAt = cyc - tr;
      end
      nCmp++;
      if (hiMuted !== 0 || edgesAfter == 0 || doneAt !== 201) begin
         nBad++;
         $display("FAIL mute got hi=%0d edges=%0d done=%0d want 0/>0/201",
                  hiMuted, edgesAfter, doneAt);
      end
   endtask
`endif

   task automatic test_random();
      int         hold [3];
      logic [2:0] tv;
      logic       m;
      m = 1'b0;
      for (int i = 0; i < 3; i++) hold[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         tv = '0;
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 299) == 0) tv[i] = 1'b1;
            if ($urandom_range(0, 999) == 0) hold[i] = $urandom_range(2, 5);
            if (hold[i] > 0) begin
               tv[i] = 1'b1;
               hold[i]--;
            end
         end
`ifdef SFX_MUTE_EN
         if ($urandom_range(0, 199) == 0) m = ~m;
`endif
         step(tv, m);
         for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (obsV[i] !== expV[i]) begin
               nBad++;
               $display("FAIL random n=%0d dut%0d got %b want %b",
                        n, i, obsV[i], expV[i]);
            end
         end
      end
      step(3'b000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_jump();
      test_win();
      test_retrigger();
      test_back_to_back();
      test_lose_rest();
      test_reset_abort();
`ifdef SFX_MUTE_EN
      test_mute();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
